// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared defaults and select encoding for the 2-to-1 mux
package mux_pkg;

  localparam int DEF_N     = 4;
  localparam int DEF_CNT_W = 16;

  typedef enum logic {
    SEL_D0 = 1'b0,
    SEL_D1 = 1'b1
  } mux_sel_e;

endpackage : mux_pkg

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - CNT_W-bit up-counter that sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;
  logic             w_full;

  assign w_full  = &r_count;
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_inc && !w_full) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule : sat_counter

// File: rtl/mux_2x1.sv
// rtl/mux_2x1.sv - N-bit 2-to-1 mux, combinational and registered outputs; MUX_2X1_SEL_CNT_EN adds a select-change counter
module mux_2x1
  import mux_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     d0,
  input  logic [N-1:0]     d1,
  input  logic             sel,
  input  logic             en,
  output logic [N-1:0]     y,
  output logic [N-1:0]     y_q,
  output logic             vld_q
`ifdef MUX_2X1_SEL_CNT_EN
  ,
  output logic [CNT_W-1:0] sel_chg_cnt
`endif
);

  mux_sel_e w_sel;

  // y ignores rst_n on purpose so it stays usable while the flops are held in reset
  assign w_sel = mux_sel_e'(sel);
  assign y     = (w_sel == SEL_D1) ? d1 : d0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= en;
      if (en) begin
        y_q <= y;
      end
    end
  end

`ifdef MUX_2X1_SEL_CNT_EN
  logic sel_prev;
  logic w_sel_chg;

  // sel_prev resets to 0, so a first captured sel=1 counts as a change
  assign w_sel_chg = en && (sel != sel_prev);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_prev <= 1'b0;
    end else if (en) begin
      sel_prev <= sel;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_sel_cnt (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_inc   (w_sel_chg),
    .o_count (sel_chg_cnt)
  );
`else
  // without the counter there is no state beyond y_q and vld_q
`endif

endmodule : mux_2x1

// File: tb/tb_mux_2x1.sv
// tb/tb_mux_2x1.sv - directed and randomized checks of mux_2x1 against a behavioural model
module tb_mux_2x1;

  localparam int N     = 4;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     d0;
  logic [N-1:0]     d1;
  logic             sel;
  logic             en;
  logic [N-1:0]     y;
  logic [N-1:0]     y_q;
  logic             vld_q;
`ifdef MUX_2X1_SEL_CNT_EN
  logic [CNT_W-1:0] sel_chg_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // reference state, kept as plain integers
  int m_yq   = 0;
  int m_vld  = 0;
  int m_cnt  = 0;
  int m_prev = 0;

  mux_2x1 #(
    .N     (N),
    .CNT_W (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .d0    (d0),
    .d1    (d1),
    .sel   (sel),
    .en    (en),
    .y     (y),
    .y_q   (y_q),
    .vld_q (vld_q)
`ifdef MUX_2X1_SEL_CNT_EN
    ,
    .sel_chg_cnt (sel_chg_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int pick(input int a, input int b, input int s);
    int data [2];
    data[0] = a;
    data[1] = b;
    return data[s];
  endfunction

  // apply inputs in the low phase, check y, clock once, update model, check registered outputs
  task automatic cycle(input logic r, input logic e, input logic s,
                       input logic [N-1:0] a, input logic [N-1:0] b, input string tag);
    int nxt;
    rst_n = r; en = e; sel = s; d0 = a; d1 = b;
    #1;
    check({tag, ".y"}, y, pick(a, b, s));
    @(posedge clk);
    nxt = pick(a, b, s);
    if (!r) begin
      m_yq = 0; m_vld = 0; m_cnt = 0; m_prev = 0;
    end else begin
      m_vld = e;
      if (e) begin
        m_yq = nxt;
        if (s != m_prev) m_cnt = (m_cnt + 1 > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : m_cnt + 1;
        m_prev = s;
      end
    end
    #1;
    check({tag, ".y_q"}, y_q, m_yq);
    check({tag, ".vld_q"}, vld_q, m_vld);
`ifdef MUX_2X1_SEL_CNT_EN
    check({tag, ".cnt"}, sel_chg_cnt, m_cnt);
`endif
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; sel = 1'b0; d0 = '0; d1 = '0;
    @(negedge clk);

    cycle(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, "reset");
    check("reset_yq_zero", y_q, 0);
    check("reset_vld_zero", vld_q, 0);

    cycle(1'b1, 1'b0, 1'b0, 4'b0001, 4'b1010, "comb_sel0");
    check("comb_sel0_val", y, 4'b0001);
    cycle(1'b1, 1'b0, 1'b1, 4'b0001, 4'b1010, "comb_sel1");
    check("comb_sel1_val", y, 4'b1010);
    cycle(1'b1, 1'b0, 1'b0, 4'b1111, 4'b0000, "swap_sel0");
    check("swap_sel0_val", y, 4'b1111);
    cycle(1'b1, 1'b0, 1'b1, 4'b1111, 4'b0000, "swap_sel1");
    check("swap_sel1_val", y, 4'b0000);

    cycle(1'b1, 1'b1, 1'b0, 4'b0001, 4'b1010, "reg_cap");
    check("reg_cap_val", y_q, 4'b0001);
    check("reg_cap_vld", vld_q, 1);
    cycle(1'b1, 1'b0, 1'b1, 4'b0110, 4'b1001, "reg_hold");
    check("reg_hold_val", y_q, 4'b0001);
    check("reg_hold_vld", vld_q, 0);

    cycle(1'b0, 1'b1, 1'b1, 4'b0000, 4'b1010, "rst_mid");
    check("rst_mid_y", y, 4'b1010);
    check("rst_mid_yq", y_q, 0);
    check("rst_mid_vld", vld_q, 0);

    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, logic'(i % 2), 4'b0011, 4'b1100, "b2b");
      check("b2b_val", y_q, (i % 2) ? 4'b1100 : 4'b0011);
      check("b2b_vld", vld_q, 1);
`ifdef MUX_2X1_SEL_CNT_EN
      check("cnt_seq", sel_chg_cnt, (i > 3) ? 3 : i);
`endif
    end
    cycle(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, "cnt_rst");

    for (int i = 0; i < 300; i++) begin
      cycle(logic'($urandom_range(0, 15) != 0), logic'($urandom_range(0, 2) != 0),
            logic'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mux_2x1
